imem_prefetch_queue: RTL



---
 rtl/imem_prefetch_queue_if.sv | 24 ++
 rtl/imem_prefetch_queue.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/imem_prefetch_queue_if.sv
// Handshake bundle for imem_prefetch_queue: IF-side valid/ready, redirect, and instruction-memory req/ack.
// master = the prefetch queue, slave = the pipeline/memory environment around it.
interface imem_prefetch_queue_if;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  fetch_ready, redirect, redirect_pc, mem_ack, mem_rdata,
    output fetch_valid, fetch_instr, fetch_pc, mem_req, mem_addr
  );

  modport slave (
    output fetch_ready, redirect, redirect_pc, mem_ack, mem_rdata,
    input  fetch_valid, fetch_instr, fetch_pc, mem_req, mem_addr
  );
endinterface

// File: rtl/imem_prefetch_queue.sv
// Sequential instruction prefetcher with a {pc, instr} FIFO feeding the IF stage; redirects flush and restart.
// Optional fetch/discard counters are enabled by defining IMEM_PREFETCH_STATS_EN.
module imem_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clock,
  input  logic                   reset,
  imem_prefetch_queue_if.master  bus
`ifdef IMEM_PREFETCH_STATS_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_discarded
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t            state;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       next_pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       pc_q    [DEPTH];
  logic [31:0]       instr_q [DEPTH];

  logic              ack_seen;
  logic              do_push;
  logic              do_pop;
  logic              do_discard;
  logic              has_room;
  logic              not_empty;
  logic [31:0]       redirect_target;

  always_comb begin
    ack_seen        = mem_req_q && bus.mem_ack;
    not_empty       = (count != '0);
    has_room        = (count < CNT_W'(DEPTH));
    do_push         = (state == REQ) && ack_seen && !bus.redirect;
    do_pop          = not_empty && bus.fetch_ready && !bus.redirect;
    // A response is thrown away when a redirect lands with it, or when it belongs to a drained request.
    do_discard      = ack_seen && (bus.redirect || (state == DRAIN));
    redirect_target = bus.redirect_pc & ~32'h0000_0003;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      next_pc    <= RESET_PC;
    end else begin
      if (bus.redirect) begin
        next_pc <= redirect_target;
      end else if (do_push) begin
        next_pc <= next_pc + 32'd4;
      end

      unique case (state)
        IDLE: begin
          if (!bus.redirect && has_room) begin
            state      <= REQ;
            mem_req_q  <= 1'b1;
            mem_addr_q <= next_pc;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end else if (bus.redirect) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (bus.redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (do_push) begin
      pc_q[wr_ptr]    <= mem_addr_q;
      instr_q[wr_ptr] <= bus.mem_rdata;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.fetch_valid = not_empty;
  assign bus.fetch_pc    = not_empty ? pc_q[rd_ptr]    : '0;
  assign bus.fetch_instr = not_empty ? instr_q[rd_ptr] : '0;

`ifdef IMEM_PREFETCH_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_fetched   <= '0;
      stat_discarded <= '0;
    end else begin
      if (do_push && (stat_fetched != '1)) begin
        stat_fetched <= stat_fetched + 32'd1;
      end
      if (do_discard && (stat_discarded != '1)) begin
        stat_discarded <= stat_discarded + 32'd1;
      end
    end
  end
`else
  logic unused_discard;
  assign unused_discard = do_discard;
`endif

endmodule
